// File: rtl/skid_pkg.sv
// Shared types for the skid_register pipeline stage.
//   state_t : occupancy state of the two-entry buffer
//   OCC_W   : width of the stored-word count
//   occ_of  : stored-word count for a given state
package skid_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    case (s)
      BUSY:    occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_register_load.sv
// Enable-loaded storage register with synchronous active-high reset to zero.
//   clk, reset : clock and synchronous reset
//   load       : capture d on the rising edge
//   d, q       : data in / registered data out
module load_register #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/skid_register.sv
// Two-entry valid/ready pipeline register (skid buffer). All outputs come
// straight from flops, so neither data nor ready paths are combinational.
//   clk, reset           : clock, synchronous active-high reset
//   s_valid_i/s_ready_o  : upstream handshake, s_data_i upstream word
//   m_valid_o/m_ready_i  : downstream handshake, m_data_o output word
//   flush_i              : discard all stored words (data contents kept)
//   occupancy_o          : stored-word count 0..2
module skid_register
  import skid_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  flush_i,
  output logic [OCC_W-1:0]      occupancy_o
);

  state_t                state_q, state_d;
  logic                  s_xfer, m_xfer;
  logic                  main_load, skid_load;
  logic [DATA_WIDTH-1:0] main_d, skid_q;

  assign s_xfer = s_valid_i & s_ready_o;
  assign m_xfer = m_valid_o & m_ready_i;

  // Status outputs are registered copies derived from the next state, so
  // they always agree with state_q without any input-to-output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      s_ready_o   <= 1'b1;
      m_valid_o   <= 1'b0;
      occupancy_o <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_o   <= (state_d != FULL);
      m_valid_o   <= (state_d != EMPTY);
      occupancy_o <= occ_of(state_d);
    end
  end

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = s_data_i;
    if (flush_i) begin
      // Validity only; stored words are left in place.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (s_xfer) begin
            state_d   = BUSY;
            main_load = 1'b1;
          end
        end
        BUSY: begin
          if (s_xfer && m_xfer) begin
            main_load = 1'b1;
          end else if (s_xfer) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (m_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (m_xfer) begin
            state_d   = BUSY;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  load_register #(.DATA_WIDTH(DATA_WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (m_data_o)
  );

  load_register #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (s_data_i),
    .q     (skid_q)
  );

endmodule
